dm_access_ctrl: RTL
===================

// Module: dm_access_ctrl
// PURPOSE
//  MEM-stage data-memory access sequencer. Accepts one load/store per pipeline request,
//  generates byte enables and lane-shifted store data, and drives a variable-latency memory
//  via req/ack. Stalls the pipeline until completion.
//  Hands raw read data plus offset/op to the load extender (DM_EXT: A, Op, Din).
// PARAMETERS
//  TIMEOUT_CYCLES  255  BUSY cycles without dm_ack_i before a bus error is declared (1..255)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  mem_valid_i  in   1   access request; held stable by pipeline while stall_o=1
//  mem_we_i     in   1   1=store, 0=load
//  mem_op_i     in   3   size/sign op; same encoding as extender Op
//  mem_addr_i   in   32  byte address
//  mem_wdata_i  in   32  store data, right-aligned
//  stall_o      out  1   freeze pipeline
//  done_o       out  1   1-cycle pulse: access complete
//  berr_o       out  1   1-cycle pulse with done_o: timeout
//  rdata_o      out  32  raw word read (to extender Din); valid with done_o
//  ext_a_o      out  2   latched mem_addr_i[1:0] (to extender A)
//  ext_op_o     out  3   latched mem_op_i (to extender Op)
//  dm_req_o     out  1   memory request, held until ack
//  dm_we_o      out  1   memory write
//  dm_addr_o    out  32  {mem_addr_i[31:2],2'b00}
//  dm_be_o      out  4   byte enables (stores); 4'b1111 for loads
//  dm_wdata_o   out  32  store data replicated into addressed lane(s)
//  dm_ack_i     in   1   memory completion; dm_rdata_i valid same cycle
//  dm_rdata_i   in   32  memory read data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; timeout counter 0. Mid-access reset drops dm_req_o immediately.
//  - Op: 000 word, 001 byte unsigned, 010 byte signed, 011 half unsigned, 100 half signed;
//    101..111 illegal, treated as word.
//  - Stores: byte uses {4{b}} with be=1<<A; half uses {2{h}} with be=A[1]?1100:0011.
//  - States: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: mem_valid_i=1 -> latch addr/op/we/data, go BUSY. stall_o = mem_valid_i (combinational).
//    BUSY: dm_req_o=1, stall_o=1, counter++.
//      dm_ack_i -> capture dm_rdata_i into rdata_o, go DONE.
//      Counter reaching TIMEOUT_CYCLES -> rdata_o=0, berr pending, go DONE.
//      Ack and timeout in the same cycle: ack wins, no berr.
//    DONE: done_o=1 (berr_o if pending), stall_o=0, dm_req_o=0; pipeline advances; go IDLE.
//  - Minimum latency: request cycle 0, dm_req_o cycle 1, ack cycle 1 -> done_o cycle 2.
//  - Back-to-back accesses: one idle cycle between DONE and the next BUSY.
//  - rdata_o, ext_a_o and ext_op_o hold their values until the next capture.
//  - dm_ack_i outside BUSY is ignored.
// CONFIGURATION
//  DM_ALIGN_EXC_EN defined:
//    - Misaligned access (word A!=0, half A[0]=1) issues no memory request.
//    - IDLE goes directly to DONE.
//    - Adds output ports:
//        exc_adel_o  out  1  load-misaligned pulse, asserted with done_o
//        exc_ades_o  out  1  store-misaligned pulse, asserted with done_o
//    - rdata_o=0 on a misaligned access.
//  DM_ALIGN_EXC_EN undefined:
//    - No alignment check; exc ports absent.
//    - Word ignores A[1:0]; half ignores A[0]; access always issued.
// STRUCTURE
//  - dm_pkg:
//      - op encodings (DM_OP_W/BU/B/HU/H)
//      - state enum (ST_IDLE/ST_BUSY/ST_DONE)
//      - be patterns
//  - dm_be_gen: combinational sub-module.
//      - inputs: op, addr[1:0], wdata
//      - outputs: be, lane-shifted wdata
//  - Top: FSM, latches, timeout counter.
// TESTING
//  - sb addr 0x1001, wdata 0x000000AB, ack next cycle
//    -> dm_be_o=0010, dm_wdata_o=0xABABABAB, dm_addr_o=0x1000, done_o at cycle 2.
//  - lh addr 0x2002, ack after 3 BUSY cycles, rdata 0xFFFF1234
//    -> stall_o=1 for 4 cycles, rdata_o=0xFFFF1234, ext_a_o=10, ext_op_o=100.
//  - No ack with TIMEOUT_CYCLES=4 -> dm_req_o drops after 4 BUSY cycles; done_o=berr_o=1; rdata_o=0.
//  - Ack on the timeout cycle -> berr_o=0, data captured.
//  - rst_n low in BUSY -> dm_req_o=0 and stall_o=0 immediately; FSM IDLE.
//  - DM_ALIGN_EXC_EN: lw addr 0x3002 -> no dm_req_o, exc_adel_o=1 with done_o at cycle 1;
//    without the macro -> dm_addr_o=0x3000, normal access.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer: op encodings,
// FSM state enum, byte-enable patterns and an op-to-size decode helper.
package dm_access_ctrl_pkg;

  // Size/sign op encodings, identical to the load extender's Op input.
  localparam logic [2:0] DM_OP_W  = 3'b000;
  localparam logic [2:0] DM_OP_BU = 3'b001;
  localparam logic [2:0] DM_OP_B  = 3'b010;
  localparam logic [2:0] DM_OP_HU = 3'b011;
  localparam logic [2:0] DM_OP_H  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } dm_size_e;

  // Byte-enable patterns; the byte pattern is shifted by the lane offset.
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Illegal ops (101..111) fall into the word bucket.
  function automatic dm_size_e op_size(input logic [2:0] op);
    dm_size_e sz;
    case (op)
      DM_OP_BU, DM_OP_B: sz = SZ_BYTE;
      DM_OP_HU, DM_OP_H: sz = SZ_HALF;
      default:           sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Data-memory bus between the access sequencer (master) and memory (slave).
//
// Handshake: dm_req_o is raised by the master and held, together with
// dm_we_o/dm_addr_o/dm_be_o/dm_wdata_o, stable until the cycle in which the
// slave asserts dm_ack_i. dm_rdata_i is valid only in that ack cycle. The
// master drops dm_req_o the cycle after ack; ack while no request is
// outstanding is ignored.
interface dm_access_ctrl_if;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    input  dm_ack_i, dm_rdata_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
    output dm_ack_i, dm_rdata_i
  );
endinterface

// File: rtl/dm_access_ctrl_be_gen.sv
// Byte-enable and store-lane generator. Stores replicate the right-aligned
// data across the word so the addressed lane(s) carry it; loads enable all
// four bytes and pass data through untouched.
module dm_access_ctrl_be_gen
  import dm_access_ctrl_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  // Select enables and replicated data from the access size and lane.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    if (we_i) begin
      case (op_size(op_i))
        SZ_BYTE: begin
          be_o    = BE_BYTE0 << addr_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          be_o    = addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = BE_WORD;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer. Latches one load/store, drives the
// memory bus until ack or timeout, then pulses done_o for one cycle and hands
// raw read data plus offset/op to the load extender.
// Optional feature macro: DM_ALIGN_EXC_EN (misaligned accesses raise an
// address exception instead of reaching memory).
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        berr_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  ext_a_o,
  output logic [2:0]  ext_op_o,
`ifdef DM_ALIGN_EXC_EN
  output logic        exc_adel_o,
  output logic        exc_ades_o,
`endif
  output dm_state_e   dbg_state_o,
  dm_access_ctrl_if.master dm
);

  // Counter value during the last BUSY cycle allowed before a timeout.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  dm_state_e   r_state;
  dm_state_e   w_state_nxt;
  logic [31:0] r_addr;
  logic [2:0]  r_op;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_berr;
  logic [31:0] r_rdata;
  logic        w_busy;
  logic        w_last;
  logic        w_timeout;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

`ifdef DM_ALIGN_EXC_EN
  logic        r_exc_adel;
  logic        r_exc_ades;
  dm_size_e    w_in_size;

  // Misalignment is judged on the live request so IDLE can bypass BUSY.
  always_comb begin
    w_in_size = op_size(mem_op_i);
    w_mis     = ((w_in_size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)) ||
                ((w_in_size == SZ_HALF) && mem_addr_i[0]);
  end
`else
  assign w_mis = 1'b0;
`endif

  assign w_busy = (r_state == ST_BUSY);
  assign w_last = (r_cnt == TO_LAST);

  // State register; reset returns to IDLE at once, dropping any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept in IDLE, wait for ack or timeout in BUSY, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid_i) w_state_nxt = w_mis ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        // An ack arriving on the final allowed cycle beats the timeout.
        w_timeout = w_last && !dm.dm_ack_i;
        if (dm.dm_ack_i || w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timeout counter: counts BUSY cycles, cleared whenever BUSY is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_cnt <= 8'd0;
    else if (w_busy && (w_state_nxt == ST_BUSY))   r_cnt <= r_cnt + 8'd1;
    else                                           r_cnt <= 8'd0;
  end

  // Request latch on accept; read data / error capture when BUSY resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_op    <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_berr  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid_i) begin
            r_addr  <= mem_addr_i;
            r_op    <= mem_op_i;
            r_we    <= mem_we_i;
            r_wdata <= mem_wdata_i;
            r_berr  <= 1'b0;
            if (w_mis) r_rdata <= '0;
          end
        end
        ST_BUSY: begin
          if (dm.dm_ack_i)  r_rdata <= dm.dm_rdata_i;
          else if (w_last)  r_rdata <= '0;
          r_berr <= w_timeout;
        end
        default: ;
      endcase
    end
  end

`ifdef DM_ALIGN_EXC_EN
  // Exception flags are decided at accept time and shown in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_adel <= 1'b0;
      r_exc_ades <= 1'b0;
    end else if ((r_state == ST_IDLE) && mem_valid_i) begin
      r_exc_adel <= w_mis && !mem_we_i;
      r_exc_ades <= w_mis && mem_we_i;
    end
  end

  assign exc_adel_o = (r_state == ST_DONE) && r_exc_adel;
  assign exc_ades_o = (r_state == ST_DONE) && r_exc_ades;
`endif

  dm_access_ctrl_be_gen u_be_gen (
    .we_i    (r_we),
    .op_i    (r_op),
    .addr_i  (r_addr[1:0]),
    .wdata_i (r_wdata),
    .be_o    (w_be),
    .wdata_o (w_wdata)
  );

  // Bus outputs are only non-zero while a request is outstanding.
  assign dm.dm_req_o   = w_busy;
  assign dm.dm_we_o    = w_busy && r_we;
  assign dm.dm_addr_o  = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dm.dm_be_o    = w_busy ? w_be : 4'd0;
  assign dm.dm_wdata_o = w_busy ? w_wdata : 32'd0;

  // Stall is gated by reset so the pipeline is released during reset.
  assign stall_o     = rst_n && (((r_state == ST_IDLE) && mem_valid_i) || w_busy);
  assign done_o      = (r_state == ST_DONE);
  assign berr_o      = (r_state == ST_DONE) && r_berr;
  assign rdata_o     = r_rdata;
  assign ext_a_o     = r_addr[1:0];
  assign ext_op_o    = r_op;
  assign dbg_state_o = r_state;

endmodule
